// File: rtl/rgu_pkg.sv
// Shared definitions for the APB reset-generation unit: register map,
// reset values and the per-channel sequencer states.
package rgu_pkg;

    localparam logic [11:0] GLB_OFF    = 12'h000;
    localparam logic [11:0] STAT_OFF   = 12'h004;
    localparam logic [11:0] TIMER0_OFF = 12'h008;
    localparam logic [11:0] TIMER1_OFF = 12'h00C;
    localparam logic [11:0] CH_BASE    = 12'h010;

    localparam logic        EN_RST     = 1'b1;
    localparam logic [31:0] TIMER0_RST = 32'd16;
    localparam logic [31:0] TIMER1_RST = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ASSERT  = 2'b01,
        ST_RELEASE = 2'b10
    } ch_state_e;

endpackage

// File: rtl/rgu_rst_channel.sv
// One software-reset channel: holds its reset low for the latched assert
// length, then stays busy for the latched release delay.
module rgu_rst_channel
    import rgu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] t_assert,
    input  logic [CNT_W-1:0] t_release,
    output logic             rst_out,
    output logic             busy,
    output logic             done
);

    ch_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] rel_r;

    // A zero length still occupies one cycle.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b0}}) ? CNT_W'(1'b1) : v;
    endfunction

    // Channel sequencer; release delay is latched at start so later timer writes do not disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            rel_r   <= {CNT_W{1'b0}};
            rst_out <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_ASSERT;
                        cnt_r   <= at_least_one(t_assert);
                        rel_r   <= t_release;
                        rst_out <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (cnt_r <= CNT_W'(1'b1)) begin
                        state_r <= ST_RELEASE;
                        cnt_r   <= at_least_one(rel_r);
                        rst_out <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1'b1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_r <= CNT_W'(1'b1)) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1'b1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    rst_out <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rgu_apb_ctrl.sv
// APB3 register front end for the reset-generation unit; register writes
// take effect at the end of the PREADY cycle.
module rgu_apb_ctrl
    import rgu_pkg::*;
#(
    parameter int NUM_CH      = 16,
    parameter int CNT_W       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [11:0]       PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NUM_CH-1:0] rst_n_o,
    output logic [NUM_CH-1:0] busy_o
);

    logic [2:0]        wait_cnt_r;
    logic              pready_r;
    logic              pslverr_r;
    logic [31:0]       prdata_r;
    logic              en_r;
    logic [NUM_CH-1:0] status_r;
    logic [CNT_W-1:0]  timer0_r;
    logic [CNT_W-1:0]  timer1_r;

    logic [9:0]        idx_s;
    logic              is_glb_s, is_stat_s, is_t0_s, is_t1_s, is_ch_s;
    logic              ch_busy_s, err_s;
    logic [31:0]       rdata_s;
    logic              access_s, last_wait_s, wr_commit_s;
    logic [NUM_CH-1:0] start_s, done_s, clr_s;

    assign PREADY  = pready_r;
    assign PSLVERR = pslverr_r;
    assign PRDATA  = prdata_r;

    // Address decode, read mux and error classification.
    always_comb begin
        idx_s     = PADDR[11:2] - 10'h004;
        is_glb_s  = (PADDR == GLB_OFF);
        is_stat_s = (PADDR == STAT_OFF);
        is_t0_s   = (PADDR == TIMER0_OFF);
        is_t1_s   = (PADDR == TIMER1_OFF);
        is_ch_s   = (PADDR[1:0] == 2'b00) && (PADDR >= CH_BASE) && (idx_s < 10'(NUM_CH));
        ch_busy_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_busy_s = (idx_s == 10'(i)) ? busy_o[i] : ch_busy_s;
        end
        rdata_s = 32'h0;
        if (is_glb_s) begin
            rdata_s[0] = en_r;
        end else if (is_stat_s) begin
            rdata_s[NUM_CH-1:0] = status_r;
        end else if (is_t0_s) begin
            rdata_s[CNT_W-1:0] = timer0_r;
        end else if (is_t1_s) begin
            rdata_s[CNT_W-1:0] = timer1_r;
        end else if (is_ch_s) begin
            rdata_s[0] = ch_busy_s;
        end else begin
            rdata_s = 32'h0;
        end
        err_s = ~(is_glb_s | is_stat_s | is_t0_s | is_t1_s | is_ch_s)
              | (PWRITE & is_ch_s & PWDATA[0] & ch_busy_s);
    end

    // Transfer timing, write qualification and channel start requests.
    always_comb begin
        access_s    = PSEL & PENABLE & ~pready_r;
        last_wait_s = access_s & (wait_cnt_r == 3'(WAIT_STATES));
        wr_commit_s = pready_r & PSEL & PENABLE & PWRITE & ~pslverr_r;
        clr_s       = (wr_commit_s & is_stat_s) ? PWDATA[NUM_CH-1:0] : {NUM_CH{1'b0}};
        start_s     = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            start_s[i] = en_r & wr_commit_s &
                         ((is_glb_s & PWDATA[1]) | (is_ch_s & PWDATA[0] & (idx_s == 10'(i))));
        end
    end

    // APB response: PREADY, PSLVERR and PRDATA are live only in the single ready cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt_r <= 3'd0;
            pready_r   <= 1'b0;
            pslverr_r  <= 1'b0;
            prdata_r   <= 32'h0;
        end else if (last_wait_s) begin
            wait_cnt_r <= 3'd0;
            pready_r   <= 1'b1;
            pslverr_r  <= err_s;
            prdata_r   <= PWRITE ? 32'h0 : rdata_s;
        end else begin
            wait_cnt_r <= access_s ? (wait_cnt_r + 3'd1) : 3'd0;
            pready_r   <= 1'b0;
            pslverr_r  <= 1'b0;
            prdata_r   <= 32'h0;
        end
    end

    // Control/status registers; a completing channel's status set beats a same-cycle clear.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            en_r     <= EN_RST;
            status_r <= {NUM_CH{1'b0}};
            timer0_r <= TIMER0_RST[CNT_W-1:0];
            timer1_r <= TIMER1_RST[CNT_W-1:0];
        end else begin
            status_r <= (status_r & ~clr_s) | done_s;
            if (wr_commit_s && is_glb_s) begin
                en_r <= PWDATA[0];
            end
            if (wr_commit_s && is_t0_s) begin
                timer0_r <= PWDATA[CNT_W-1:0];
            end
            if (wr_commit_s && is_t1_s) begin
                timer1_r <= PWDATA[CNT_W-1:0];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rgu_rst_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (PCLK),
            .rst_n    (PRESETn),
            .start    (start_s[g]),
            .t_assert (timer0_r),
            .t_release(timer1_r),
            .rst_out  (rst_n_o[g]),
            .busy     (busy_o[g]),
            .done     (done_s[g])
        );
    end

endmodule
